// File: rtl/bexkat1Def.sv
// Shared type definitions for the bexkat1 bus blocks.
// Latency: none (types only).
// Backpressure: not applicable.
package bexkat1Def;

  // Arbiter ownership of the shared slave bus.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DM,
    ARB_IM
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (DM priority, IM anti-starvation) to one-slave bus arbiter with watchdog.
// Latency: request into idle granted at next edge; ack/err routed combinationally.
// Backpressure: slave stalls by withholding bus_ack_i; after TIMEOUT grant cycles err ends the transfer.
//
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   dm_* / im_*                          master request side (cyc, we, adr, dat, sel in; ack, err, dat out)
//   bus_cyc_o .. bus_sel_o               muxed request toward the slave
//   bus_ack_i, bus_dat_i                 slave response
//   grant_o                              one-hot owner, bit1 = DM, bit0 = IM
module bus_arbiter
  import bexkat1Def::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int IM_STARVE = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dm_cyc_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_adr_i,
  input  logic [31:0] dm_dat_i,
  input  logic [3:0]  dm_sel_i,
  output logic        dm_ack_o,
  output logic        dm_err_o,
  output logic [31:0] dm_dat_o,
  input  logic        im_cyc_i,
  input  logic        im_we_i,
  input  logic [31:0] im_adr_i,
  input  logic [31:0] im_dat_i,
  input  logic [3:0]  im_sel_i,
  output logic        im_ack_o,
  output logic        im_err_o,
  output logic [31:0] im_dat_o,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_dat_i,
  output logic [1:0]  grant_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(IM_STARVE + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(IM_STARVE);

  arb_state_t    state, state_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;

  logic dm_gnt, im_gnt, own_cyc, tmo_hit, arb_now;

  assign dm_gnt  = (state == ARB_DM);
  assign im_gnt  = (state == ARB_IM);
  assign own_cyc = (dm_gnt & dm_cyc_i) | (im_gnt & im_cyc_i);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // A grant ends on ack, on timeout, or when its owner drops cyc; idle
  // arbitrates every cycle. Ack without an owning cyc is an abort anyway.
  assign arb_now = (state == ARB_IDLE) | ~own_cyc | bus_ack_i | tmo_hit;

  assign dm_ack_o = bus_ack_i & dm_gnt & dm_cyc_i;
  assign im_ack_o = bus_ack_i & im_gnt & im_cyc_i;
  assign dm_err_o = dm_gnt & dm_cyc_i & ~bus_ack_i & tmo_hit;
  assign im_err_o = im_gnt & im_cyc_i & ~bus_ack_i & tmo_hit;
  assign dm_dat_o = bus_dat_i;
  assign im_dat_o = bus_dat_i;
  assign grant_o  = {dm_gnt, im_gnt};

  always_comb begin
    bus_cyc_o = 1'b0;
    bus_we_o  = 1'b0;
    bus_adr_o = '0;
    bus_dat_o = '0;
    bus_sel_o = '0;
    if (dm_gnt) begin
      bus_cyc_o = dm_cyc_i;
      bus_we_o  = dm_we_i;
      bus_adr_o = dm_adr_i;
      bus_dat_o = dm_dat_i;
      bus_sel_o = dm_sel_i;
    end else if (im_gnt) begin
      bus_cyc_o = im_cyc_i;
      bus_we_o  = im_we_i;
      bus_adr_o = im_adr_i;
      bus_dat_o = im_dat_i;
      bus_sel_o = im_sel_i;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    tmo_nxt    = tmo_cnt;
    if (arb_now) begin
      // Every new grant starts its own watchdog window.
      tmo_nxt = '0;
      if (dm_cyc_i && !(im_cyc_i && starve_cnt == STARVE_MAX)) begin
        state_nxt = ARB_DM;
        // DM only wins a contested arbitration below the limit, so the
        // increment cannot wrap.
        starve_nxt = im_cyc_i ? starve_cnt + SW'(1) : '0;
      end else if (im_cyc_i) begin
        state_nxt  = ARB_IM;
        starve_nxt = '0;
      end else begin
        state_nxt  = ARB_IDLE;
        starve_nxt = '0;
      end
    end else begin
      // tmo_hit forces arbitration, so this never exceeds TIMEOUT-1.
      tmo_nxt = tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ARB_IDLE;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled 2 units later.
// Backpressure: slave stalls and timeouts are modelled by holding bus_ack_i low.
module tb_bus_arbiter;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_STARVE  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dm_cyc_i, dm_we_i, im_cyc_i, im_we_i;
  logic [31:0] dm_adr_i, dm_dat_i, im_adr_i, im_dat_i;
  logic [3:0]  dm_sel_i, im_sel_i;
  logic        dm_ack_o, dm_err_o, im_ack_o, im_err_o;
  logic [31:0] dm_dat_o, im_dat_o;
  logic        bus_cyc_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel_o;
  logic [1:0]  grant_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.TIMEOUT(TB_TIMEOUT), .IM_STARVE(TB_STARVE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dm_cyc_i(dm_cyc_i), .dm_we_i(dm_we_i), .dm_adr_i(dm_adr_i), .dm_dat_i(dm_dat_i),
    .dm_sel_i(dm_sel_i), .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o), .dm_dat_o(dm_dat_o),
    .im_cyc_i(im_cyc_i), .im_we_i(im_we_i), .im_adr_i(im_adr_i), .im_dat_i(im_dat_i),
    .im_sel_i(im_sel_i), .im_ack_o(im_ack_o), .im_err_o(im_err_o), .im_dat_o(im_dat_o),
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
    .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i), .bus_dat_i(bus_dat_i), .grant_o(grant_o)
  );

  // Layout: grant, bus cyc/we/adr/dat/sel, dm ack/err/dat, im ack/err/dat.
  function automatic logic [139:0] outs();
    return {grant_o, bus_cyc_o, bus_we_o, bus_adr_o, bus_dat_o, bus_sel_o,
            dm_ack_o, dm_err_o, dm_dat_o, im_ack_o, im_err_o, im_dat_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    dm_cyc_i = 0; dm_we_i = 0; dm_adr_i = 0; dm_dat_i = 0; dm_sel_i = 0;
    im_cyc_i = 0; im_we_i = 0; im_adr_i = 0; im_dat_i = 0; im_sel_i = 0;
    bus_ack_i = 0; bus_dat_i = 0;
  endtask

  task automatic cleanup();
    drive_idle();
    step();
    step();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_i = 1;
    dm_cyc_i = 1; dm_adr_i = 32'h55; im_cyc_i = 1; im_adr_i = 32'h77;
    #3;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_outs got=%h want=0", outs());
    end
    step(); step();
    settle();
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_held got=%h want=0", outs());
    end
    rst_i = 0;
    settle();
    checks++;
    if (grant_o !== 2'b00) begin
      failures++; $display("FAIL reset_release_nogrant got=%b want=00", grant_o);
    end
    step();
    settle();
    checks++;
    if (grant_o !== 2'b10) begin
      failures++; $display("FAIL reset_first_grant got=%b want=10", grant_o);
    end
    cleanup();
  endtask

  task automatic test_im_read();
    im_cyc_i = 1; im_we_i = 0; im_adr_i = 32'h1000; im_sel_i = 4'hf;
    settle();
    checks++;
    if (bus_cyc_o !== 1'b0) begin
      failures++; $display("FAIL im_read_req_cycle bus_cyc got=%b want=0", bus_cyc_o);
    end
    for (int w = 0; w < 2; w++) begin
      step();
      settle();
      checks++;
      if ({grant_o, bus_cyc_o, bus_adr_o, im_ack_o} !== {2'b01, 1'b1, 32'h1000, 1'b0}) begin
        failures++;
        $display("FAIL im_read_wait%0d got grant=%b cyc=%b adr=%h ack=%b want 01 1 00001000 0",
                 w, grant_o, bus_cyc_o, bus_adr_o, im_ack_o);
      end
    end
    step();
    bus_ack_i = 1; bus_dat_i = 32'hDEADBEEF;
    settle();
    checks++;
    if ({im_ack_o, im_dat_o, dm_ack_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("FAIL im_read_ack got ack=%b dat=%h dm_ack=%b want 1 deadbeef 0",
               im_ack_o, im_dat_o, dm_ack_o);
    end
    im_cyc_i = 0; bus_ack_i = 0;
    step();
    settle();
    checks++;
    if ({im_ack_o, grant_o, bus_cyc_o} !== {1'b0, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL im_read_after got ack=%b grant=%b cyc=%b want 0 00 0", im_ack_o, grant_o, bus_cyc_o);
    end
    cleanup();
  endtask

  task automatic test_simultaneous();
    dm_cyc_i = 1; dm_we_i = 1; dm_adr_i = 32'h2000; dm_sel_i = 4'b0011; dm_dat_i = 32'h12345678;
    im_cyc_i = 1; im_we_i = 0; im_adr_i = 32'h3000; im_sel_i = 4'hf;
    step();
    bus_ack_i = 1;
    settle();
    checks++;
    if ({grant_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o, dm_ack_o, im_ack_o} !==
        {2'b10, 1'b1, 32'h2000, 4'b0011, 32'h12345678, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL simul_dm_first got grant=%b we=%b adr=%h sel=%b dat=%h dmack=%b imack=%b want 10 1 00002000 0011 12345678 1 0",
               grant_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o, dm_ack_o, im_ack_o);
    end
    dm_cyc_i = 0; bus_ack_i = 0;
    step();
    settle();
    checks++;
    if ({grant_o, bus_cyc_o, bus_we_o, bus_adr_o} !== {2'b01, 1'b1, 1'b0, 32'h3000}) begin
      failures++;
      $display("FAIL simul_im_next got grant=%b cyc=%b we=%b adr=%h want 01 1 0 00003000",
               grant_o, bus_cyc_o, bus_we_o, bus_adr_o);
    end
    cleanup();
  endtask

  task automatic test_starvation();
    int dm_done;
    dm_done = 0;
    dm_cyc_i = 1; dm_adr_i = 32'hA0; im_cyc_i = 1; im_adr_i = 32'hB0; bus_ack_i = 1;
    settle();
    checks++;
    if (dm_ack_o !== 1'b0 || im_ack_o !== 1'b0) begin
      failures++; $display("FAIL starve_idle_ack got dm=%b im=%b want 0 0", dm_ack_o, im_ack_o);
    end
    for (int n = 0; n < 16; n++) begin
      step();
      settle();
      if (grant_o === 2'b01) break;
      if (dm_ack_o === 1'b1) dm_done++;
    end
    checks++;
    if (dm_done != TB_STARVE || grant_o !== 2'b01 || im_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL starve_limit got dm_xfers=%0d grant=%b imack=%b want %0d 01 1",
               dm_done, grant_o, im_ack_o, TB_STARVE);
    end
    step();
    settle();
    checks++;
    if (grant_o !== 2'b10) begin
      failures++; $display("FAIL starve_back_to_dm got=%b want=10", grant_o);
    end
    cleanup();
  endtask

  task automatic test_timeout();
    for (int rep = 0; rep < 2; rep++) begin
      dm_cyc_i = 1; dm_adr_i = 32'h4000;
      step();
      for (int i = 1; i <= TB_TIMEOUT; i++) begin
        bus_ack_i = (rep == 1 && i == TB_TIMEOUT);
        settle();
        checks++;
        if (rep == 0 && {dm_err_o, dm_ack_o, bus_cyc_o} !== {(i == TB_TIMEOUT), 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL timeout_cycle%0d got err=%b ack=%b cyc=%b want %b 0 1",
                   i, dm_err_o, dm_ack_o, bus_cyc_o, (i == TB_TIMEOUT));
        end
        if (rep == 1 && {dm_err_o, dm_ack_o} !== {1'b0, (i == TB_TIMEOUT)}) begin
          failures++;
          $display("FAIL timeout_ack_wins%0d got err=%b ack=%b want 0 %b",
                   i, dm_err_o, dm_ack_o, (i == TB_TIMEOUT));
        end
        if (i == TB_TIMEOUT) begin
          dm_cyc_i = 0; bus_ack_i = 0;
        end
        step();
      end
      settle();
      checks++;
      if (bus_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
        failures++;
        $display("FAIL timeout_release%0d got cyc=%b grant=%b want 0 00", rep, bus_cyc_o, grant_o);
      end
      cleanup();
    end
  endtask

  task automatic test_abort();
    im_cyc_i = 1; im_adr_i = 32'h5000;
    step();
    dm_cyc_i = 1; dm_adr_i = 32'h6000;
    settle();
    checks++;
    if (grant_o !== 2'b01 || bus_cyc_o !== 1'b1) begin
      failures++; $display("FAIL abort_wait got grant=%b cyc=%b want 01 1", grant_o, bus_cyc_o);
    end
    step();
    im_cyc_i = 0; bus_ack_i = 1;
    settle();
    checks++;
    if ({bus_cyc_o, im_ack_o, dm_ack_o, grant_o} !== {1'b0, 1'b0, 1'b0, 2'b01}) begin
      failures++;
      $display("FAIL abort_cycle got cyc=%b imack=%b dmack=%b grant=%b want 0 0 0 01",
               bus_cyc_o, im_ack_o, dm_ack_o, grant_o);
    end
    bus_ack_i = 0;
    step();
    settle();
    checks++;
    if ({grant_o, bus_cyc_o, bus_adr_o} !== {2'b10, 1'b1, 32'h6000}) begin
      failures++;
      $display("FAIL abort_regrant got grant=%b cyc=%b adr=%h want 10 1 00006000", grant_o, bus_cyc_o, bus_adr_o);
    end
    cleanup();
  endtask

  task automatic test_reset_mid();
    // Drive the starvation count to its limit so a missed clear would hand IM the bus.
    dm_cyc_i = 1; im_cyc_i = 1; bus_ack_i = 1;
    for (int n = 0; n < TB_STARVE; n++) step();
    bus_ack_i = 0;
    settle();
    checks++;
    if (grant_o !== 2'b10 || bus_cyc_o !== 1'b1) begin
      failures++; $display("FAIL midreset_pre got grant=%b cyc=%b want 10 1", grant_o, bus_cyc_o);
    end
    rst_i = 1;
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL midreset_outs got=%h want=0", outs());
    end
    step();
    rst_i = 0;
    step();
    settle();
    checks++;
    if (grant_o !== 2'b10) begin
      failures++; $display("FAIL midreset_counter_clear got=%b want=10", grant_o);
    end
    cleanup();
  endtask

  // Reference model: owner 0=none 1=IM 2=DM; waited = completed grant cycles of
  // the current transfer; streak = contested DM wins since IM last got served.
  task automatic test_random();
    int owner, waited, streak;
    logic dc, ic, ocyc, eda, ede, eia, eie, ewe;
    logic [1:0] eg;
    logic [31:0] eadr, edat;
    logic [3:0] esel;
    logic [139:0] expv;
    owner = 0; waited = 0; streak = 0; dc = 0; ic = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) dc = ~dc;
      if ($urandom_range(0, 4) == 0) ic = ~ic;
      dm_cyc_i = dc; dm_we_i = 1'($urandom); dm_adr_i = $urandom; dm_dat_i = $urandom; dm_sel_i = 4'($urandom);
      im_cyc_i = ic; im_we_i = 1'($urandom); im_adr_i = $urandom; im_dat_i = $urandom; im_sel_i = 4'($urandom);
      bus_ack_i = ($urandom_range(0, 5) == 0); bus_dat_i = $urandom;
      settle();
      ocyc = (owner == 2) ? dc : (owner == 1) ? ic : 1'b0;
      eg   = (owner == 2) ? 2'b10 : (owner == 1) ? 2'b01 : 2'b00;
      ewe  = (owner == 2) ? dm_we_i  : (owner == 1) ? im_we_i  : 1'b0;
      eadr = (owner == 2) ? dm_adr_i : (owner == 1) ? im_adr_i : 32'h0;
      edat = (owner == 2) ? dm_dat_i : (owner == 1) ? im_dat_i : 32'h0;
      esel = (owner == 2) ? dm_sel_i : (owner == 1) ? im_sel_i : 4'h0;
      eda  = (owner == 2) && dc && bus_ack_i;
      eia  = (owner == 1) && ic && bus_ack_i;
      ede  = (owner == 2) && dc && !bus_ack_i && (waited == TB_TIMEOUT - 1);
      eie  = (owner == 1) && ic && !bus_ack_i && (waited == TB_TIMEOUT - 1);
      expv = {eg, ocyc, ewe, eadr, edat, esel, eda, ede, bus_dat_i, eia, eie, bus_dat_i};
      checks++;
      if (outs() !== expv) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h want=%h", n, outs(), expv);
      end
      if (owner == 0 || !ocyc || bus_ack_i || waited == TB_TIMEOUT - 1) begin
        if (!ic) streak = 0;
        if (dc && !(ic && streak >= TB_STARVE)) begin
          owner = 2;
          if (ic) streak = (streak < TB_STARVE) ? streak + 1 : TB_STARVE;
        end else if (ic) begin
          owner = 1; streak = 0;
        end else begin
          owner = 0;
        end
        waited = 0;
      end else begin
        waited++;
      end
      step();
    end
    cleanup();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive_idle();
    rst_i = 1;
    step();
    test_reset();
    test_im_read();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
